// File: rtl/sum_window_acc.sv
// Collects WINDOW accepted sum samples into a saturating accumulator, then
// presents one total/max/overflow record that is held until the sink takes it.
module sum_window_acc #(
    parameter int IN_W   = 9,
    parameter int WINDOW = 4,
    parameter int ACC_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [IN_W-1:0]  out_max,
    output logic             out_ovf
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int SUM_W = ((IN_W > ACC_W) ? IN_W : ACC_W) + 1;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [ACC_W-1:0]   r_acc;
    logic [IN_W-1:0]    r_runMax;
    logic               r_ovfAcc;
    logic [CNT_W-1:0]   r_cnt;

    logic [ACC_W-1:0]   r_outSum;
    logic [IN_W-1:0]    r_outMax;
    logic               r_outOvf;

    logic               w_hold;
    logic               w_accept;
    logic               w_close;
    logic [SUM_W-1:0]   w_nsum;
    logic               w_winOvf;
    logic [ACC_W-1:0]   w_newAcc;
    logic [IN_W-1:0]    w_newMax;

    assign w_hold   = (r_state == HOLD);
    assign w_accept = in_valid && in_ready;
    assign w_close  = w_accept && (r_cnt == CNT_W'(WINDOW - 1));

    // Sum is formed one bit wider than the accumulator so a carry out flags overflow.
    assign w_nsum   = SUM_W'(r_acc) + SUM_W'(in_data);
    assign w_winOvf = (|w_nsum[SUM_W-1:ACC_W]) || r_ovfAcc;
    assign w_newAcc = w_winOvf ? {ACC_W{1'b1}} : w_nsum[ACC_W-1:0];
    assign w_newMax = (in_data > r_runMax) ? in_data : r_runMax;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A close during HOLD means the old record was just taken; the new one replaces it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ACCUM: begin
                if (w_close) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (w_close) begin
                    w_nextState = HOLD;
                end else if (out_ready) begin
                    w_nextState = ACCUM;
                end
            end
            default: w_nextState = ACCUM;
        endcase
    end

    always_comb begin
        out_valid = w_hold;
        in_ready  = !w_hold || out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_runMax <= '0;
            r_ovfAcc <= 1'b0;
            r_cnt    <= '0;
            r_outSum <= '0;
            r_outMax <= '0;
            r_outOvf <= 1'b0;
        end else if (w_accept) begin
            if (w_close) begin
                r_outSum <= w_newAcc;
                r_outMax <= w_newMax;
                r_outOvf <= w_winOvf;
                r_acc    <= '0;
                r_runMax <= '0;
                r_ovfAcc <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_acc    <= w_newAcc;
                r_runMax <= w_newMax;
                r_ovfAcc <= w_winOvf;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_sum = r_outSum;
    assign out_max = r_outMax;
    assign out_ovf = r_outOvf;

endmodule

// File: tb/tb_sum_window_acc.sv
// Drives three differently-sized windows from one shared stimulus stream and
// checks every presented record against a queue-based window model.
module tb_sum_window_acc;

    typedef struct {
        int sum;
        int mx;
        bit ovf;
    } rec_t;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [8:0]  inData;
    logic        outReady;

    logic        inReadyA, inReadyB, inReadyC;
    logic        outValidA, outValidB, outValidC;
    logic [10:0] outSumA;
    logic [9:0]  outSumB;
    logic [8:0]  outSumC;
    logic [8:0]  outMaxA, outMaxB, outMaxC;
    logic        outOvfA, outOvfB, outOvfC;

    logic        inReadyArr[3];
    logic        outValidArr[3];
    logic [10:0] outSumArr[3];
    logic [8:0]  outMaxArr[3];
    logic        outOvfArr[3];

    int winP[3]  = '{4, 3, 1};
    int accWP[3] = '{11, 10, 9};

    rec_t expQ[3][$];
    int   mSum[3];
    int   mMax[3];
    int   mCnt[3];

    int compared   = 0;
    int mismatched = 0;
    bit started    = 0;

    sum_window_acc #(.IN_W(9), .WINDOW(4), .ACC_W(11)) dutA (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyA), .in_data(inData),
        .out_valid(outValidA), .out_ready(outReady), .out_sum(outSumA), .out_max(outMaxA),
        .out_ovf(outOvfA)
    );

    sum_window_acc #(.IN_W(9), .WINDOW(3), .ACC_W(10)) dutB (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyB), .in_data(inData),
        .out_valid(outValidB), .out_ready(outReady), .out_sum(outSumB), .out_max(outMaxB),
        .out_ovf(outOvfB)
    );

    sum_window_acc #(.IN_W(9), .WINDOW(1), .ACC_W(9)) dutC (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyC), .in_data(inData),
        .out_valid(outValidC), .out_ready(outReady), .out_sum(outSumC), .out_max(outMaxC),
        .out_ovf(outOvfC)
    );

    assign inReadyArr[0]  = inReadyA;
    assign inReadyArr[1]  = inReadyB;
    assign inReadyArr[2]  = inReadyC;
    assign outValidArr[0] = outValidA;
    assign outValidArr[1] = outValidB;
    assign outValidArr[2] = outValidC;
    assign outSumArr[0]   = outSumA;
    assign outSumArr[1]   = {1'b0, outSumB};
    assign outSumArr[2]   = {2'b0, outSumC};
    assign outMaxArr[0]   = outMaxA;
    assign outMaxArr[1]   = outMaxB;
    assign outMaxArr[2]   = outMaxC;
    assign outOvfArr[0]   = outOvfA;
    assign outOvfArr[1]   = outOvfB;
    assign outOvfArr[2]   = outOvfC;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Window model: sum every accepted sample of a window with plain integers,
    // then clip to the accumulator range and flag if the clip was needed.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                expQ[k].delete();
                mSum[k] = 0;
                mMax[k] = 0;
                mCnt[k] = 0;
            end else begin
                bit   ready;
                int   lim;
                rec_t r;
                ready = (expQ[k].size() == 0) || outReady;
                if (expQ[k].size() > 0 && outReady) void'(expQ[k].pop_front());
                if (inValid && ready) begin
                    mSum[k] += int'(inData);
                    if (int'(inData) > mMax[k]) mMax[k] = int'(inData);
                    mCnt[k]++;
                    if (mCnt[k] == winP[k]) begin
                        lim   = (1 << accWP[k]) - 1;
                        r.ovf = (mSum[k] > lim);
                        r.sum = r.ovf ? lim : mSum[k];
                        r.mx  = mMax[k];
                        expQ[k].push_back(r);
                        mSum[k] = 0;
                        mMax[k] = 0;
                        mCnt[k] = 0;
                    end
                end
            end
        end
        if (rst) started = 1;
    end

    // Monitor: whenever a record is presented it must match the queue head.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                bit expV;
                expV = (expQ[k].size() > 0);
                compared++;
                if (outValidArr[k] !== expV) begin
                    mismatched++;
                    $display("[TB] FAIL out_valid[%0d] t=%0t: got %b, expected %b", k, $time, outValidArr[k], expV);
                end
                compared++;
                if (inReadyArr[k] !== (!expV || outReady)) begin
                    mismatched++;
                    $display("[TB] FAIL in_ready[%0d] t=%0t: got %b, expected %b", k, $time, inReadyArr[k], (!expV || outReady));
                end
                if (expV && outValidArr[k] === 1'b1) begin
                    rec_t r;
                    r = expQ[k][0];
                    compared++;
                    if (outSumArr[k] !== 11'(r.sum) || outMaxArr[k] !== 9'(r.mx) || outOvfArr[k] !== r.ovf) begin
                        mismatched++;
                        $display("[TB] FAIL record[%0d] t=%0t: got sum=%0d max=%0d ovf=%b, expected sum=%0d max=%0d ovf=%b",
                                 k, $time, outSumArr[k], outMaxArr[k], outOvfArr[k], r.sum, r.mx, r.ovf);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input bit r, input bit v, input int d, input bit rdy);
        rst      = r;
        inValid  = v;
        inData   = 9'(d);
        outReady = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int k, input string name, input logic [10:0] got, input logic [10:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s[%0d]: got %0d, expected %0d", name, k, got, exp);
        end
    endtask

    task automatic send(input int d);
        applyStimulus(1'b0, 1'b1, d, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        inValid  = 1'b1;
        inData   = 9'd77;
        outReady = 1'b1;
        applyStimulus(1'b1, 1'b1, 77, 1'b1);
        applyStimulus(1'b1, 1'b1, 77, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput(k, "rst_valid", 11'(outValidArr[k]), 11'd0);
            checkOutput(k, "rst_sum", outSumArr[k], 11'd0);
            checkOutput(k, "rst_max", 11'(outMaxArr[k]), 11'd0);
            checkOutput(k, "rst_ovf", 11'(outOvfArr[k]), 11'd0);
        end

        $display("[TB] basic window");
        send(100); send(200); send(300); send(400);
        idle(2);

        $display("[TB] gaps and backpressure");
        send(10); idle(1); send(20); idle(2); send(30); send(40);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 99, 1'b0);
        send(1); send(2); send(3); send(4);
        idle(2);

        $display("[TB] saturation");
        for (int i = 0; i < 4; i++) send(511);
        for (int i = 0; i < 4; i++) send(1);
        idle(2);

        $display("[TB] reset mid-window and during hold");
        send(50); send(60);
        applyStimulus(1'b1, 1'b1, 55, 1'b1);
        send(10); send(20); send(30); send(40);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        idle(2);

        $display("[TB] single-sample streaming");
        send(5); send(7); send(9);
        idle(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? (511 - int'($urandom_range(0, 20))) : int'($urandom_range(0, 511));
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sum_window_acc.md
Name: sum_window_acc

Overview:
Downstream consumer of the 9-bit adder result `y`. It collects WINDOW accepted sum samples over a valid/ready handshake and adds them into an accumulator. When a window closes, it emits one result record holding the window total, the window maximum and an overflow flag. The record is held until the sink accepts it, and the block applies backpressure upstream while a record is pending.

Parameters:
- IN_W, 9, width of incoming sum samples (matches adder output `y`).
- WINDOW, 4, samples per window; legal range >= 1.
- ACC_W, 11, accumulator/result width; may be set smaller than IN_W+clog2(WINDOW), in which case saturation applies.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  IN_W  unsigned sum sample.
- out_valid  out  1  result record valid.
- out_ready  in  1  sink accepts the record.
- out_sum  out  ACC_W  window total, unsigned, saturating.
- out_max  out  IN_W  largest sample in the window.
- out_ovf  out  1  window total exceeded 2^ACC_W-1.

Behaviour:
- States:
  - ACCUM: collecting samples.
  - HOLD: out_valid=1, waiting for out_ready.
- Reset (rst=1 at a clk edge): state=ACCUM, internal acc=0, cnt=0, run_max=0, ovf_acc=0.
  - Outputs: out_valid=0, out_sum=0, out_max=0, out_ovf=0.
  - Reset has priority over every other event, including mid-window and during HOLD. Partial windows and pending records are discarded.
- in_ready = !out_valid || out_ready. This is combinational from out_ready, giving a pass-through while the sink drains.
- A sample is accepted when in_valid && in_ready. Idle cycles (in_valid=0) do not advance cnt.
- On each accepted sample:
  - Compute nsum = acc + in_data in ACC_W+1 bits.
  - If nsum[ACC_W]=1 or ovf_acc=1: the window is overflowed and acc saturates to 2^ACC_W-1.
  - run_max = max(run_max, in_data).
  - cnt increments.
- Window close: the accepted sample with cnt==WINDOW-1. On that clk edge:
  - out_sum, out_max and out_ovf load the final values, and out_valid goes to 1 (state HOLD).
  - acc, run_max, ovf_acc and cnt clear to 0.
  - Latency: out_valid is high in the cycle immediately after the WINDOW-th accepted sample.
- HOLD:
  - While out_ready=0, out_sum/out_max/out_ovf stay bit-stable and in_ready=0.
  - When out_valid && out_ready: if no window closes that cycle, out_valid goes to 0 next cycle (state ACCUM).
- Simultaneous record accept and window close (same cycle; only possible when WINDOW=1 or when sink-ready overlaps the close): the new record wins. out_valid stays 1 with the new values; no record is lost or duplicated.
- With the default parameters (4 x 511 = 2044 < 2048), overflow is unreachable. out_ovf is meaningful only for reduced ACC_W.
- No output may be X/Z at any clk edge after the first reset.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_sum=0, out_max=0, out_ovf=0, no sample counted after release.
- Basic window: back-to-back 100, 200, 300, 400 with out_ready=1 -> cycle after 4th beat: out_valid=1, out_sum=1000, out_max=400, out_ovf=0, for exactly 1 cycle.
- Gaps plus backpressure: 10, idle, 20, idle, idle, 30, 40, out_ready=0 for 5 cycles -> record 100/40/0 held stable and in_ready=0 throughout. Raise out_ready -> in_ready=1 the same cycle; next window 1, 2, 3, 4 -> 10/4/0.
- Overflow (ACC_W=10): four beats of 511 -> out_sum=1023, out_max=511, out_ovf=1. Next window 1, 1, 1, 1 -> out_sum=4, out_ovf=0.
- Reset mid-operation: accept 50, 60, then rst for 1 cycle, then 10, 20, 30, 40 -> out_sum=100, out_max=40 (old samples discarded). Reset asserted during HOLD drops out_valid the next cycle.
- WINDOW=1 streaming: out_ready=1, inputs 5, 7, 9 on consecutive cycles -> out_valid held high for 3 cycles with out_sum 5, 7, 9, no drops.
